ddram_arbiter: RTL and testbench

Shares the single DDR3 Avalon port between three toggle-handshake clients: the ROM loader write path, the console ROM read path and the backup-RAM (SRAM save) path. It sits between the `ddram`-side DDRAM_* bus and the clients. A one-line 64-bit read cache serves repeated ROM fetches without a DDR3 transaction. It converts byte addresses into 64-bit word addresses with byte enables.

---
 rtl/ddram_pkg.sv | 20 ++
 rtl/rom_line_cache.sv | 46 ++++
 rtl/ddram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_ddram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddram_pkg.sv
// Shared types and defaults for the DDR3 port arbiter.
package ddram_pkg;

    typedef enum logic [1:0] {IDLE, WR, RD, RDW} state_t;
    typedef enum logic [1:0] {CL_WR, CL_ROM, CL_SRAM} client_t;

    localparam logic [3:0]  BASE_DEF     = 4'b0011;
    localparam logic [24:0] SRAM_OFS_DEF = 25'h1F00000;

    // Byte enables for a 16-bit lane inside the 64-bit word.
    function automatic logic [7:0] be16(input logic [1:0] sel);
        return 8'b11 << {sel, 1'b0};
    endfunction

    // Pick one 16-bit lane out of a 64-bit word.
    function automatic logic [15:0] sel16(input logic [63:0] d, input logic [1:0] sel);
        return d[{sel, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/rom_line_cache.sv
// Single-line 64-bit ROM read cache: tag/valid/data with hit compare,
// fill from DDR3 and invalidation by flush pulse or overlapping write.
module rom_line_cache
    import ddram_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [21:0] lookup_tag_i,
    output logic        hit_o,
    output logic [63:0] data_o,
    input  logic        fill_i,
    input  logic [21:0] fill_tag_i,
    input  logic [63:0] fill_data_i,
    input  logic        inv_i,
    input  logic        wr_chk_i,
    input  logic [21:0] wr_tag_i
);

    logic        valid_q;
    logic [21:0] tag_q;
    logic [63:0] data_q;

    assign hit_o  = valid_q && (tag_q == lookup_tag_i);
    assign data_o = data_q;

    // Flush wins over a same-cycle fill; a write to the cached word drops the line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            if (fill_i) begin
                tag_q  <= fill_tag_i;
                data_q <= fill_data_i;
            end
            if (inv_i)
                valid_q <= 1'b0;
            else if (wr_chk_i && (wr_tag_i == tag_q))
                valid_q <= 1'b0;
            else if (fill_i)
                valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/ddram_arbiter.sv
// Arbitrates the DDR3 Avalon port between the ROM loader, ROM reads and
// backup-RAM accesses. Loader has fixed priority, ROM/SRAM round-robin,
// ROM reads served from a one-line cache when possible.
module ddram_arbiter
    import ddram_pkg::*;
#(
    parameter logic [3:0]  BASE     = BASE_DEF,
    parameter logic [24:0] SRAM_OFS = SRAM_OFS_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    input  logic [24:0] wr_addr,
    input  logic [15:0] wr_din,
    input  logic        wr_req,
    output logic        wr_ack,
    input  logic [24:0] rom_addr,
    output logic [63:0] rom_dout,
    input  logic        rom_req,
    output logic        rom_ack,
    input  logic [15:0] sram_addr,
    input  logic [15:0] sram_din,
    output logic [15:0] sram_dout,
    input  logic        sram_we,
    input  logic        sram_req,
    output logic        sram_ack,
    input  logic        cache_inv
);

    state_t      state_q;
    client_t     client_q;
    logic        last_rom_q;
    logic        we_q, rd_q;
    logic [28:0] addr_q;
    logic [63:0] din_q;
    logic [7:0]  be_q;
    logic        wr_ack_q, rom_ack_q, sram_ack_q;
    logic [63:0] rom_dout_q;
    logic [15:0] sram_dout_q;
    logic [1:0]  sram_sel_q;

    logic        gnt_wr_d, gnt_rom_d, gnt_sram_d, hit_ack_d;
    logic        rom_hit, line_fill, inv_chk;
    logic [21:0] inv_tag;
    logic [63:0] line_data;
    logic [24:0] sram_baddr;
    logic        unused_bits;

    wire wr_pend   = wr_req   != wr_ack_q;
    wire rom_pend  = rom_req  != rom_ack_q;
    wire sram_pend = sram_req != sram_ack_q;

    assign sram_baddr  = SRAM_OFS + {9'b0, sram_addr};
    assign unused_bits = ^{rom_addr[2:0], wr_addr[0], sram_baddr[0]};

    // Pick at most one action per IDLE cycle; a hit never consumes the ROM turn.
    always_comb begin
        gnt_wr_d   = 1'b0;
        gnt_rom_d  = 1'b0;
        gnt_sram_d = 1'b0;
        hit_ack_d  = 1'b0;
        if (state_q == IDLE) begin
            if (wr_pend)                                   gnt_wr_d   = 1'b1;
            else if (rom_pend && rom_hit)                  hit_ack_d  = 1'b1;
            else if (rom_pend && (!sram_pend || !last_rom_q)) gnt_rom_d = 1'b1;
            else if (sram_pend)                            gnt_sram_d = 1'b1;
        end
    end

    assign inv_chk   = gnt_wr_d || (gnt_sram_d && sram_we);
    assign inv_tag   = gnt_wr_d ? wr_addr[24:3] : sram_baddr[24:3];
    assign line_fill = (state_q == RDW) && DDRAM_DOUT_READY && (client_q == CL_ROM);

    rom_line_cache u_cache (
        .clk_i        (clk_sys),
        .rst_ni       (reset_n),
        .lookup_tag_i (rom_addr[24:3]),
        .hit_o        (rom_hit),
        .data_o       (line_data),
        .fill_i       (line_fill),
        .fill_tag_i   (addr_q[21:0]),
        .fill_data_i  (DDRAM_DOUT),
        .inv_i        (cache_inv),
        .wr_chk_i     (inv_chk),
        .wr_tag_i     (inv_tag)
    );

    // Transaction FSM with registered command, data and handshake outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            client_q    <= CL_WR;
            last_rom_q  <= 1'b0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            be_q        <= '0;
            wr_ack_q    <= 1'b0;
            rom_ack_q   <= 1'b0;
            sram_ack_q  <= 1'b0;
            rom_dout_q  <= '0;
            sram_dout_q <= '0;
            sram_sel_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_wr_d) begin
                        addr_q   <= {BASE, 3'b000, wr_addr[24:3]};
                        din_q    <= {4{wr_din}};
                        be_q     <= be16(wr_addr[2:1]);
                        we_q     <= 1'b1;
                        client_q <= CL_WR;
                        state_q  <= WR;
                    end else if (hit_ack_d) begin
                        rom_dout_q <= line_data;
                        rom_ack_q  <= ~rom_ack_q;
                    end else if (gnt_rom_d) begin
                        addr_q     <= {BASE, 3'b000, rom_addr[24:3]};
                        be_q       <= 8'hFF;
                        rd_q       <= 1'b1;
                        client_q   <= CL_ROM;
                        last_rom_q <= 1'b1;
                        state_q    <= RD;
                    end else if (gnt_sram_d) begin
                        addr_q     <= {BASE, 3'b000, sram_baddr[24:3]};
                        client_q   <= CL_SRAM;
                        last_rom_q <= 1'b0;
                        sram_sel_q <= sram_baddr[2:1];
                        if (sram_we) begin
                            din_q   <= {4{sram_din}};
                            be_q    <= be16(sram_baddr[2:1]);
                            we_q    <= 1'b1;
                            state_q <= WR;
                        end else begin
                            be_q    <= 8'hFF;
                            rd_q    <= 1'b1;
                            state_q <= RD;
                        end
                    end
                end
                WR: begin
                    if (!DDRAM_BUSY) begin
                        we_q    <= 1'b0;
                        state_q <= IDLE;
                        if (client_q == CL_WR) wr_ack_q   <= ~wr_ack_q;
                        else                   sram_ack_q <= ~sram_ack_q;
                    end
                end
                RD: begin
                    if (!DDRAM_BUSY) begin
                        rd_q    <= 1'b0;
                        state_q <= RDW;
                    end
                end
                RDW: begin
                    if (DDRAM_DOUT_READY) begin
                        state_q <= IDLE;
                        if (client_q == CL_ROM) begin
                            rom_dout_q <= DDRAM_DOUT;
                            rom_ack_q  <= ~rom_ack_q;
                        end else begin
                            sram_dout_q <= sel16(DDRAM_DOUT, sram_sel_q);
                            sram_ack_q  <= ~sram_ack_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_RD       = rd_q;
    assign wr_ack         = wr_ack_q;
    assign rom_ack        = rom_ack_q;
    assign sram_ack       = sram_ack_q;
    assign rom_dout       = rom_dout_q;
    assign sram_dout      = sram_dout_q;

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: DDR3 slave memory plus a word-level reference
// memory and an abstract "last ROM word read" cache model.
module tb_ddram_arbiter;

    localparam logic [24:0] SOFS = 25'h1F00000;
    localparam int          SKEY = 32'h1F00000 >> 3;

    logic        clk_sys, reset_n;
    logic        DDRAM_BUSY, DDRAM_DOUT_READY;
    logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN, DDRAM_DOUT;
    logic        DDRAM_WE, DDRAM_RD;
    logic [24:0] wr_addr, rom_addr;
    logic [15:0] wr_din, sram_addr, sram_din, sram_dout;
    logic        wr_req, wr_ack, rom_req, rom_ack, sram_we, sram_req, sram_ack, cache_inv;
    logic [63:0] rom_dout;

    ddram_arbiter #(.BASE(4'b0011), .SRAM_OFS(SOFS)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR),
        .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE), .DDRAM_RD(DDRAM_RD),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .wr_addr(wr_addr), .wr_din(wr_din), .wr_req(wr_req), .wr_ack(wr_ack),
        .rom_addr(rom_addr), .rom_dout(rom_dout), .rom_req(rom_req), .rom_ack(rom_ack),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout), .sram_we(sram_we),
        .sram_req(sram_req), .sram_ack(sram_ack), .cache_inv(cache_inv)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Word-addressed memories, keyed by byte_addr >> 3.
    logic [63:0] ref_mem [int];
    logic [63:0] ddr_mem [int];
    bit c_valid;
    int c_key;

    function automatic logic [63:0] init_word(input int key);
        return {10'h2A5, key[21:0], 10'h15A, ~key[21:0]};
    endfunction
    function automatic logic [63:0] ref_get(input int key);
        return ref_mem.exists(key) ? ref_mem[key] : init_word(key);
    endfunction
    function automatic logic [63:0] ddr_get(input int key);
        return ddr_mem.exists(key) ? ddr_mem[key] : init_word(key);
    endfunction

    task automatic ref_wr(input int key, input logic [1:0] sel, input logic [15:0] d);
        logic [63:0] w;
        w = ref_get(key);
        w[sel*16 +: 16] = d;
        ref_mem[key] = w;
        if (c_valid && c_key == key) c_valid = 0;
    endtask

    // DDR3 slave: decides BUSY for the coming edge, commits accepted commands.
    int  busy_force = 0;
    bit  busy_rand = 0, spur_en = 0, rd_rand = 0;
    int  rd_lat = 3, rd_cnt = 0, rd_key = 0, rd_acc = 0, wr_acc = 0;
    initial begin
        DDRAM_BUSY = 0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 0;
        forever begin
            @(negedge clk_sys);
            DDRAM_DOUT_READY = 0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    DDRAM_DOUT = ddr_get(rd_key);
                    DDRAM_DOUT_READY = 1;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                DDRAM_DOUT = {$urandom, $urandom};
                DDRAM_DOUT_READY = 1;
            end
            if (busy_force > 0 && (DDRAM_WE || DDRAM_RD)) begin
                DDRAM_BUSY = 1;
                busy_force--;
            end else begin
                DDRAM_BUSY = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            if (!DDRAM_BUSY && reset_n && (DDRAM_WE || DDRAM_RD)) begin
                int key;
                logic [63:0] w;
                chk("ddr_base", {57'b0, DDRAM_ADDR[28:22]}, 64'h18);
                key = int'(DDRAM_ADDR[21:0]);
                if (DDRAM_WE) begin
                    w = ddr_get(key);
                    for (int b = 0; b < 8; b++)
                        if (DDRAM_BE[b]) w[b*8 +: 8] = DDRAM_DIN[b*8 +: 8];
                    ddr_mem[key] = w;
                    wr_acc++;
                end else begin
                    rd_key = key;
                    rd_cnt = rd_rand ? $urandom_range(1, 6) : rd_lat;
                    rd_acc++;
                end
            end
        end
    end

    // Wait for a client's ack, recording latency and the command seen on the bus.
    int          n_cyc, cmd_cyc, rd0;
    bit          cmd_moved;
    logic [28:0] cmd_addr;
    logic [63:0] cmd_din;
    logic [7:0]  cmd_be;

    task automatic wait_ack(input int cl);
        bit done;
        done = 0; n_cyc = 0; cmd_cyc = 0; cmd_moved = 0; rd0 = rd_acc;
        while (!done && n_cyc < 200) begin
            @(negedge clk_sys);
            n_cyc++;
            if (DDRAM_WE || DDRAM_RD) begin
                if (cmd_cyc == 0) begin
                    cmd_addr = DDRAM_ADDR; cmd_din = DDRAM_DIN; cmd_be = DDRAM_BE;
                end else if ({DDRAM_ADDR, DDRAM_DIN, DDRAM_BE} != {cmd_addr, cmd_din, cmd_be}) begin
                    cmd_moved = 1;
                end
                cmd_cyc++;
            end
            case (cl)
                0:       done = (wr_ack == wr_req);
                1:       done = (rom_ack == rom_req);
                default: done = (sram_ack == sram_req);
            endcase
        end
        if (!done) chk("ack_timeout", {63'b0, done}, 64'd1);
    endtask

    task automatic op_wr(input logic [24:0] a, input logic [15:0] d);
        wr_addr = a; wr_din = d; wr_req = ~wr_req;
        wait_ack(0);
        ref_wr(int'(a[24:3]), a[2:1], d);
    endtask

    task automatic op_rom(input logic [24:0] a);
        int key;
        bit exp_hit;
        key = int'(a[24:3]);
        exp_hit = c_valid && (c_key == key);
        rom_addr = a; rom_req = ~rom_req;
        wait_ack(1);
        chk("rom_dout", rom_dout, ref_get(key));
        chk("rom_dram_rd", 64'(rd_acc - rd0), exp_hit ? 64'd0 : 64'd1);
        if (exp_hit) chk("rom_hit_lat", 64'(n_cyc), 64'd1);
        c_valid = 1; c_key = key;
    endtask

    task automatic op_sram(input logic [15:0] a, input logic we, input logic [15:0] d);
        logic [24:0] full;
        logic [63:0] w;
        full = SOFS + {9'b0, a};
        sram_addr = a; sram_we = we; sram_din = d; sram_req = ~sram_req;
        wait_ack(2);
        if (we) begin
            ref_wr(int'(full[24:3]), full[2:1], d);
        end else begin
            w = ref_get(int'(full[24:3]));
            chk("sram_dout", {48'b0, sram_dout}, {48'b0, w[full[2:1]*16 +: 16]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int kp [6];
        logic [24:0] rq_addr [3];
        int ev_exp [6];
        int ev_n, ev_cl, rom_iss, sram_iss;
        logic pa_rom, pa_sram, pa_wr;
        logic [63:0] w;

        kp = '{32'h40, 32'h41, 32'h42, SKEY, SKEY + 1, SKEY + 2};
        rq_addr = '{25'h1000, 25'h1008, 25'h1010};
        ev_exp = '{1, 2, 0, 1, 2, 1};

        reset_n = 0; wr_addr = '0; wr_din = '0; wr_req = 0; rom_addr = '0; rom_req = 0;
        sram_addr = '0; sram_din = '0; sram_we = 0; sram_req = 0; cache_inv = 0; c_valid = 0;
        repeat (3) @(negedge clk_sys);
        reset_n = 1;
        @(negedge clk_sys);

        // reset state
        chk("rst_acks", {61'b0, wr_ack, rom_ack, sram_ack}, 64'd0);
        chk("rst_cmd", {62'b0, DDRAM_WE, DDRAM_RD}, 64'd0);
        chk("rst_burst", {56'b0, DDRAM_BURSTCNT}, 64'd1);
        chk("rst_addr", {35'b0, DDRAM_ADDR}, 64'd0);
        chk("rst_din", DDRAM_DIN, 64'd0);
        chk("rst_be", {56'b0, DDRAM_BE}, 64'd0);
        chk("rst_rom_dout", rom_dout, 64'd0);
        chk("rst_sram_dout", {48'b0, sram_dout}, 64'd0);

        // loader write, BUSY low
        op_wr(25'h000006, 16'hBEEF);
        chk("wr_lat", 64'(n_cyc), 64'd2);
        chk("wr_we_cyc", 64'(cmd_cyc), 64'd1);
        chk("wr_addr", {35'b0, cmd_addr}, {35'b0, 4'b0011, 25'h0});
        chk("wr_be", {56'b0, cmd_be}, 64'hC0);
        chk("wr_din", cmd_din, {4{16'hBEEF}});

        // loader write with BUSY high for 4 cycles
        busy_force = 4;
        op_wr(25'h00000A, 16'h1234);
        chk("busy_lat", 64'(n_cyc), 64'd6);
        chk("busy_we_cyc", 64'(cmd_cyc), 64'd5);
        chk("busy_stable", {63'b0, cmd_moved}, 64'd0);
        chk("busy_be", {56'b0, cmd_be}, 64'h0C);
        chk("busy_din", cmd_din, {4{16'h1234}});
        repeat (3) @(negedge clk_sys);
        chk("busy_one_ack", {63'b0, wr_ack}, {63'b0, wr_req});

        // ROM miss with 5-cycle DDR latency, then a hit on the same line
        ddr_mem[32'h20] = 64'h0123456789ABCDEF;
        ref_mem[32'h20] = 64'h0123456789ABCDEF;
        rd_lat = 5;
        op_rom(25'h000100);
        chk("rom_miss_lat", 64'(n_cyc), 64'd7);
        op_rom(25'h000104);

        // SRAM write into the cached word forces the next ROM read to DDR3
        rd_lat = 3;
        op_rom(SOFS + 25'h10);
        op_sram(16'h0012, 1'b1, 16'hCAFE);
        op_rom(SOFS + 25'h10);
        op_rom(SOFS + 25'h10);
        cache_inv = 1; @(negedge clk_sys); cache_inv = 0; c_valid = 0;
        op_rom(SOFS + 25'h10);
        op_sram(16'h0000, 1'b0, 16'h0);

        // ROM/SRAM alternate; loader raised mid-stream wins the next IDLE
        ev_n = 0; rom_iss = 1; sram_iss = 1;
        pa_rom = rom_ack; pa_sram = sram_ack; pa_wr = wr_ack;
        rom_addr = rq_addr[0]; rom_req = ~rom_req;
        sram_addr = 16'h0020; sram_we = 0; sram_req = ~sram_req;
        for (int t = 0; t < 400 && ev_n < 6; t++) begin
            @(negedge clk_sys);
            ev_cl = -1;
            if (wr_ack != pa_wr) ev_cl = 0;
            else if (rom_ack != pa_rom) ev_cl = 1;
            else if (sram_ack != pa_sram) ev_cl = 2;
            if (ev_cl >= 0) begin
                chk("alt_order", 64'(ev_cl), 64'(ev_exp[ev_n]));
                ev_n++;
            end
            if (ev_cl == 0) begin
                pa_wr = wr_ack;
                ref_wr(int'(wr_addr[24:3]), wr_addr[2:1], wr_din);
            end else if (ev_cl == 1) begin
                pa_rom = rom_ack;
                chk("alt_rom_dout", rom_dout, ref_get(int'(rom_addr[24:3])));
                c_valid = 1; c_key = int'(rom_addr[24:3]);
                if (rom_iss < 3) begin
                    rom_addr = rq_addr[rom_iss]; rom_req = ~rom_req; rom_iss++;
                end
            end else if (ev_cl == 2) begin
                pa_sram = sram_ack;
                w = ref_get(SKEY + int'(sram_addr[15:3]));
                chk("alt_sram_dout", {48'b0, sram_dout}, {48'b0, w[15:0]});
                if (ev_n == 2) begin
                    wr_addr = 25'h2000; wr_din = 16'h5A5A; wr_req = ~wr_req;
                end
                if (sram_iss < 2) begin
                    sram_addr = 16'h0028; sram_req = ~sram_req; sram_iss++;
                end
            end
        end
        chk("alt_events", 64'(ev_n), 64'd6);

        // reset during RDW abandons the read and empties the cache
        rd_lat = 20;
        rom_addr = 25'h3000; rom_req = ~rom_req;
        repeat (6) @(negedge clk_sys);
        reset_n = 0;
        #1;
        chk("mid_rst_acks", {61'b0, wr_ack, rom_ack, sram_ack}, 64'd0);
        chk("mid_rst_cmd", {62'b0, DDRAM_WE, DDRAM_RD}, 64'd0);
        chk("mid_rst_addr", {35'b0, DDRAM_ADDR}, 64'd0);
        chk("mid_rst_dout", rom_dout, 64'd0);
        rd_cnt = 0; wr_req = 0; rom_req = 0; sram_req = 0; c_valid = 0;
        @(negedge clk_sys);
        reset_n = 1;
        @(negedge clk_sys);
        rd_lat = 2;
        op_rom(25'h000104);
        chk("post_rst_lat", 64'(n_cyc), 64'd4);

        // randomized mix against the reference memory and cache model
        busy_rand = 1; spur_en = 1; rd_rand = 1;
        for (int i = 0; i < 80; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 2)
                op_wr(25'(kp[$urandom_range(0, 5)] * 8 + $urandom_range(0, 7)), 16'($urandom));
            else if (r <= 6)
                op_rom(25'(kp[$urandom_range(0, 5)] * 8 + $urandom_range(0, 7)));
            else if (r <= 8)
                op_sram(16'($urandom_range(0, 2) * 8 + $urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom));
            else begin
                cache_inv = 1; @(negedge clk_sys); cache_inv = 0; c_valid = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
